// File: rtl/doe_sbox_arb_pkg.sv
// Shared types and constants for the DOE S-box arbiter: FSM states, requester ids
// and the default burst limit.
package doe_sbox_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } doe_sbox_arb_state_e;

  localparam logic DOE_SBOX_REQ_KEY    = 1'b0;
  localparam logic DOE_SBOX_REQ_CIPHER = 1'b1;

  localparam int DOE_SBOX_ARB_BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/doe_sbox_arb_sbox.sv
// DOE S-box: four parallel byte substitutions (GF(2^8) inverse followed by the
// affine transform), purely combinational.
module doe_sbox_arb_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign sub_word[8*g +: 8] = sbox_byte(word[8*g +: 8]);
  end

endmodule

// File: rtl/doe_sbox_arb.sv
// Two-requester arbiter for the shared DOE S-box: round-robin between key memory
// and cipher datapath, burst ownership with forced release, registered responses.
module doe_sbox_arb
  import doe_sbox_arb_pkg::*;
#(
  parameter int BURST_MAX = DOE_SBOX_ARB_BURST_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req0_valid,
  input  logic                req0_last,
  input  logic [31:0]         req0_word,
  output logic                req0_ready,
  output logic                rsp0_valid,
  output logic [31:0]         rsp0_word,
  input  logic                req1_valid,
  input  logic                req1_last,
  input  logic [31:0]         req1_word,
  output logic                req1_ready,
  output logic                rsp1_valid,
  output logic [31:0]         rsp1_word,
  output logic                busy,
  output logic                burst_cut,
  output doe_sbox_arb_state_e dbg_state
);

  localparam int CW = $clog2(BURST_MAX + 1);

  // Handshake: a beat transfers in any cycle where valid && ready; ready is a
  // function of valid, state and last_grant only, so valid must not wait on ready.
  doe_sbox_arb_state_e state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                cut_q, cut_d;
  logic                rdy0, rdy1;
  logic                acc_any, acc_last;
  logic [31:0]         sbox_in, sbox_out;
  logic                rsp0_valid_q, rsp1_valid_q;
  logic [31:0]         rsp0_word_q, rsp1_word_q;

  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = req0_valid && (!req1_valid || (last_grant_q == DOE_SBOX_REQ_CIPHER));
        rdy1 = req1_valid && (!req0_valid || (last_grant_q == DOE_SBOX_REQ_KEY));
      end
      OWN0:    rdy0 = req0_valid;
      OWN1:    rdy1 = req1_valid;
      default: ;
    endcase
  end

  // Gated by reset so no beat is offered while the block is held in reset.
  assign req0_ready = reset_n && rdy0;
  assign req1_ready = reset_n && rdy1;

  assign acc_any  = req0_ready || req1_ready;
  assign acc_last = req1_ready ? req1_last : req0_last;
  assign sbox_in  = req1_ready ? req1_word : req0_word;
  assign cnt_inc  = (cnt_q >= CW'(BURST_MAX)) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    cut_d        = 1'b0;
    if (acc_any) last_grant_d = req1_ready ? DOE_SBOX_REQ_CIPHER : DOE_SBOX_REQ_KEY;
    unique case (state_q)
      IDLE: begin
        if (acc_any && !acc_last && (BURST_MAX > 1)) begin
          state_d = req1_ready ? OWN1 : OWN0;
          cnt_d   = CW'(1);
        end
      end
      OWN0, OWN1: begin
        if (acc_any) begin
          if (acc_last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CW'(BURST_MAX)) begin
            // Forced release: the owner re-arbitrates for the rest of its burst.
            state_d = IDLE;
            cnt_d   = '0;
            cut_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= DOE_SBOX_REQ_CIPHER;
      cnt_q        <= '0;
      cut_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      cut_q        <= cut_d;
    end
  end

  doe_sbox_arb_sbox u_sbox (
    .word     (sbox_in),
    .sub_word (sbox_out)
  );

  // Each requester keeps its own result register so its word holds until its next response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_word_q  <= '0;
      rsp1_word_q  <= '0;
    end else begin
      rsp0_valid_q <= req0_ready;
      rsp1_valid_q <= req1_ready;
      if (req0_ready) rsp0_word_q <= sbox_out;
      if (req1_ready) rsp1_word_q <= sbox_out;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_word  = rsp0_word_q;
  assign rsp1_word  = rsp1_word_q;
  assign busy       = (state_q != IDLE);
  assign burst_cut  = cut_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/doe_sbox_arb.md
# doe_sbox_arb

Two-requester arbiter and sequencer for the shared 32-bit DOE S-box (four parallel byte substitutions). Requester 0 (key memory / key expansion) and requester 1 (cipher round datapath) share the lookup through valid/ready handshakes with optional multi-beat bursts. Results return through a registered response stage one cycle after acceptance. The block sits between `doe_key_mem`, the cipher core and the single S-box instance.

## Interface
Parameters:
- `BURST_MAX`, default 4: maximum accepted beats per grant before forced release. Legal range is ≥1.

Ports (reset is asynchronous, active-low; all logic is clocked on `clk`):
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `req0_valid`  in  1  requester 0 has a word to substitute
- `req0_last`  in  1  final beat of requester 0's burst
- `req0_word`  in  32  word to substitute
- `req0_ready`  out  1  beat accepted this cycle (`valid && ready`)
- `rsp0_valid`  out  1  one-cycle pulse; `rsp0_word` holds a result
- `rsp0_word`  out  32  S-box of the accepted word
- `req1_valid`, `req1_last`, `req1_word`, `req1_ready`, `rsp1_valid`, `rsp1_word`: same as requester 0, for requester 1
- `busy`  out  1  a burst is owned (state ≠ IDLE)
- `burst_cut`  out  1  one-cycle pulse; a burst was force-released at `BURST_MAX`

## Operation
- **States:** IDLE, OWN0, OWN1. A `last_grant` bit resets to 1, so requester 0 wins the first tie.
- **IDLE:**
  - Only one requester is valid: it gets `ready` combinationally.
  - Both are valid: `ready` goes to the requester ≠ `last_grant`.
  - The accepted beat updates `last_grant`.
  - If the beat is not last and `BURST_MAX` > 1, go to OWNx with `beat_cnt` = 1. Otherwise stay in IDLE.
- **OWNx:**
  - Only requester x can receive `ready`; the other's `ready` is 0.
  - An accepted beat increments `beat_cnt`.
  - Return to IDLE on an accepted beat with `last`, or when `beat_cnt` reaches `BURST_MAX`.
  - On the `BURST_MAX` exit with `last` = 0, pulse `burst_cut` the following cycle. The requester must re-arbitrate for the remainder of its burst.
  - If owner `valid` is low, the grant is held and no beat is consumed. `last` is only sampled when `valid` is high.
- **Datapath:**
  - The mux selects the granted word into the S-box submodule.
  - Result and requester id are registered on acceptance.
  - `rspX_valid` is the registered accept strobe for requester X.
  - `rspX_word` holds its value until the next response to X.
  - Responses have no backpressure; the requester must consume them.
- **Ready rule:** `ready` depends on `valid` and on state only. Requesters must not make `valid` depend on `ready`.
- **Width rules:** `beat_cnt` is `$clog2(BURST_MAX+1)` bits and saturates at `BURST_MAX`.

## Timing
- **Throughput:** 1 beat per cycle; lookup latency is exactly 1 cycle (accept in cycle N, `rsp_valid` in N+1).
- **Reset values:** every output is 0 (`req*_ready`, `rsp*_valid`, `rsp*_word`, `busy`, `burst_cut`); state is IDLE, `last_grant` = 1, `beat_cnt` = 0.
- **Reset mid-burst:** the in-flight response is dropped (`rsp_valid` is not asserted after reset release). Arbitration restarts in IDLE with the reset tie-break.
- **Simultaneous exit and request:** on an OWNx exit cycle the other requester is not granted. It is granted at the earliest in the next cycle (IDLE), ahead of x because `last_grant` = x.
- **`BURST_MAX` = 1:** OWN states are unreachable; the block acts as pure round-robin.

## Structure
- Package `doe_sbox_arb_pkg`:
  - state enum `doe_sbox_arb_state_e`
  - requester id constants `DOE_SBOX_REQ_KEY` = 0 and `DOE_SBOX_REQ_CIPHER` = 1
  - `DOE_SBOX_ARB_BURST_MAX_DEFAULT` = 4
- One submodule instance of the existing DOE S-box module (32-bit word in, 32-bit word out).
- The arbiter FSM, counter and response register are inline.

## Test plan
- **Single requester:** req0 word 0x00010203 with `last` = 1 → `req0_ready` the same cycle; next cycle `rsp0_valid` = 1, `rsp0_word` = 0x637c777b; `rsp1_valid` stays 0.
- **Tie from reset:** both valid, words 0x52535455 and 0xffffffff, `last` = 1.
  - Cycle 0: req0 granted.
  - Cycle 1: req1 granted; `rsp0_word` = 0x00ed20fc.
  - Cycle 2: `rsp1_word` = 0x16161616.
- **Burst lock:** req1 sends 3 beats with `last` on the third while req0 is continuously valid → req0 `ready` stays 0 for all three beats; req0 is granted in the cycle after the exit; `busy` is high only during OWN1.
- **Forced cut:** `BURST_MAX` = 4, req0 sends 6 beats of 0x5f5f5f5f with `last` only on beat 6.
  - Release after beat 4; `burst_cut` pulses once.
  - req1 (valid) is granted next.
  - All six `rsp0_word` = 0xcfcfcfcf.
- **Hold while idle:** in OWN0, drop `req0_valid` for 3 cycles while req1 is valid → no grant to req1 and `busy` stays 1; req0 resumes and completes with `last`.
- **Reset mid-burst:** assert `reset_n` low in the cycle after an accepted non-last beat → all outputs are 0 immediately; after release no `rsp_valid` appears and a tie grants req0.
